input_cal_seq: RTL
==================

Name: input_cal_seq

Overview:
- Parametrised N-channel ADC input calibrator: per-channel offset subtract, gain multiply, arithmetic shift, then signed saturation.
- Sits between the ADC sample deserialiser and DSP cores. Time-multiplexes one multiplier across all channels, once per sample strobe.
- Adds runtime coefficient writes, atomic output update with valid strobe, bypass mode, overrun flag and correct signed clamping.

Parameters:
- N_CH, 4: channel count (≥1).
- W, 16: sample width, signed.
- COEF_W, 16: offset/gain coefficient width, signed.
- SHIFT, 10: right shift after multiply; unity gain = 1<<SHIFT.
- CLAMP_HI, 28000: upper saturation limit (signed, fits W).
- CLAMP_LO, -28000: lower saturation limit (signed, fits W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_strobe  in  1  one-cycle pulse in the clk domain: new samples on adc_in.
- adc_in  in  N_CH*W  raw samples, channel c at bits [c*W +: W], signed.
- bypass  in  1  sampled with sample_strobe; 1 = skip offset/gain, clamp only.
- cal_we  in  1  coefficient write enable.
- cal_waddr  in  $clog2(2*N_CH)  address 2c = offset of channel c, 2c+1 = gain of channel c.
- cal_wdata  in  COEF_W  coefficient value, signed.
- cal_out  out  N_CH*W  calibrated samples, same packing as adc_in.
- out_valid  out  1  one-cycle pulse when cal_out updates.
- busy  out  1  high while a sample set is in flight.
- overrun  out  1  sticky: strobe arrived while busy.

Behaviour:
- Reset values:
  - cal_out = 0, out_valid = 0, busy = 0, overrun = 0.
  - All offsets = 0; all gains = 1<<SHIFT.
  - Pipeline flushed; channel counter = 0.
- States:
  - IDLE: strobe && !rst → latch all of adc_in and bypass, counter = 0, busy = 1 → RUN.
  - RUN: issues channels 0..N_CH-1, one per cycle. After the last issue → DRAIN.
  - DRAIN: waits for the pipeline to empty, then → IDLE.
- Pipeline, strobe sampled at edge T0:
  - Channel c at T0+1+c: diff = latched_c − offset_c, W+1 bits; gain_c is captured in the same cycle.
  - At T0+2+c: prod = diff × gain_c, full width W+1+COEF_W, signed.
  - At T0+3+c: res = prod >>> SHIFT (arithmetic, floor), then clamped to [CLAMP_LO, CLAMP_HI] by full-width signed compare. Written to shadow register c.
- Output update:
  - At T0+N_CH+3, all shadow registers copy to cal_out in the same cycle, out_valid = 1 for one cycle, busy = 0.
  - Latency is N_CH+3 cycles (7 at default). cal_out holds between updates.
- Bypass: res = clamp(latched_c); offset and gain are ignored; timing is identical.
- Strobe while busy: strobe is ignored, overrun set to 1 (sticky until rst), and the in-flight set completes unaffected.
- Strobe in the same cycle busy falls: treated as busy, so it is ignored and sets overrun.
- Coefficient writes:
  - Accepted in any state.
  - A write in the same cycle a channel reads the same address returns the old value (read-before-write).
  - An out-of-range address (≥2*N_CH) is ignored.
- rst mid-operation: aborts the set, no out_valid, and all reset values apply on the next cycle, including coefficients.
- rst and strobe in the same cycle: reset wins and the strobe is dropped.

Test Plan:
- Reset defaults, N_CH=4: adc_in = {1000, −1000, 0, 27999}, strobe at T0 → out_valid only at T0+7; cal_out = {1000, −1000, 0, 27999}; busy high T0+1..T0+7.
- Coefficients: ch1 offset=100, gain=2048; adc ch1=1100 → 2000. Same coefficients with adc ch1=−900 → −2000. Other channels are unaffected.
- Clamp: ch0 gain=4096.
  - adc 10000 → 28000; adc −10000 → −28000.
  - Gain=1024 with adc −32768 → −28000 (no wrap).
  - Gain=−1024 with adc −32768 → 28000.
- Bypass: bypass=1 with strobe, ch2 gain=4096, adc 30000 → 28000 and adc 500 → 500; latency still 7.
- Overrun: strobes at T0 and T0+2 → single out_valid at T0+7 from the T0 data; overrun = 1 until rst. A strobe at T0+8 processes normally.
- Reset mid-flight: strobe at T0, rst at T0+3 → no out_valid; cal_out = 0, busy = 0, gains back to 1024. The next strobe gives unity results.

Source files
------------

// File: rtl/input_cal_seq.sv
// input_cal_seq: N-channel ADC calibrator (offset, gain, shift, saturate).
// One shared multiplier walks the channels once per sample strobe.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sample_strobe   - one-cycle pulse: new sample set on adc_in
//   adc_in          - raw signed samples, channel c at [c*W +: W]
//   bypass          - sampled with strobe: clamp only, no offset/gain
//   cal_we/waddr/wdata - coefficient write (2c = offset, 2c+1 = gain)
//   cal_out         - calibrated samples, same packing as adc_in
//   out_valid       - one-cycle pulse when cal_out updates
//   busy            - sample set in flight
//   overrun         - sticky: strobe seen while busy
module input_cal_seq #(
    parameter int N_CH     = 4,
    parameter int W        = 16,
    parameter int COEF_W   = 16,
    parameter int SHIFT    = 10,
    parameter int CLAMP_HI = 28000,
    parameter int CLAMP_LO = -28000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_strobe,
    input  logic [N_CH*W-1:0]            adc_in,
    input  logic                         bypass,
    input  logic                         cal_we,
    input  logic [$clog2(2*N_CH)-1:0]    cal_waddr,
    input  logic [COEF_W-1:0]            cal_wdata,
    output logic [N_CH*W-1:0]            cal_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int AW = $clog2(2*N_CH);
    localparam int PW = W + 1 + COEF_W;
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic signed [PW-1:0]     HI_P  = PW'(CLAMP_HI);
    localparam logic signed [PW-1:0]     LO_P  = PW'(CLAMP_LO);
    localparam logic signed [W-1:0]      HI_W  = W'(CLAMP_HI);
    localparam logic signed [W-1:0]      LO_W  = W'(CLAMP_LO);
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << SHIFT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [1:0]                dcnt;
    logic                      lat_byp;
    logic signed [W-1:0]       lat    [N_CH];
    logic signed [COEF_W-1:0]  off    [N_CH];
    logic signed [COEF_W-1:0]  gain   [N_CH];
    logic signed [W-1:0]       shadow [N_CH];

    // Stage 1: offset subtract, gain captured alongside
    logic                      s1_v;
    logic [CW-1:0]             s1_ch;
    logic                      s1_byp;
    logic signed [W:0]         s1_diff;
    logic signed [COEF_W-1:0]  s1_gain;

    // Stage 2: full-width product
    logic                      s2_v;
    logic [CW-1:0]             s2_ch;
    logic                      s2_byp;
    logic signed [PW-1:0]      s2_prod;

    // Stage 3 (combinational into shadow): shift and saturate.
    // Bypass carries the raw sample in s2_prod, so it skips the shift.
    logic signed [PW-1:0]      res_full;
    logic signed [W-1:0]       res_w;

    always_comb begin
        res_full = s2_byp ? s2_prod : (s2_prod >>> SHIFT);
        if (res_full > HI_P) begin
            res_w = HI_W;
        end else if (res_full < LO_P) begin
            res_w = LO_W;
        end else begin
            res_w = res_full[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dcnt      <= '0;
            lat_byp   <= 1'b0;
            s1_v      <= 1'b0;
            s1_ch     <= '0;
            s1_byp    <= 1'b0;
            s1_diff   <= '0;
            s1_gain   <= '0;
            s2_v      <= 1'b0;
            s2_ch     <= '0;
            s2_byp    <= 1'b0;
            s2_prod   <= '0;
            cal_out   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                lat[c]    <= '0;
                off[c]    <= '0;
                gain[c]   <= UNITY;
                shadow[c] <= '0;
            end
        end else begin
            out_valid <= 1'b0;

            // Coefficient writes land after this edge; any channel
            // reading the same entry this cycle sees the old value.
            // Addresses with no matching channel fall through.
            if (cal_we) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (cal_waddr == AW'(2*c)) begin
                        off[c] <= cal_wdata;
                    end
                    if (cal_waddr == AW'(2*c + 1)) begin
                        gain[c] <= cal_wdata;
                    end
                end
            end

            // busy mirrors state != IDLE, so this covers the cycle
            // in which busy falls as well.
            if (sample_strobe && busy) begin
                overrun <= 1'b1;
            end

            // Stage 1 issue
            s1_v   <= (state == RUN);
            s1_ch  <= cnt;
            s1_byp <= lat_byp;
            if (state == RUN) begin
                s1_gain <= gain[cnt];
                if (lat_byp) begin
                    s1_diff <= (W+1)'(lat[cnt]);
                end else begin
                    s1_diff <= (W+1)'(lat[cnt]) - (W+1)'(off[cnt]);
                end
            end

            // Stage 2 multiply
            s2_v   <= s1_v;
            s2_ch  <= s1_ch;
            s2_byp <= s1_byp;
            if (s1_v) begin
                if (s1_byp) begin
                    s2_prod <= PW'(s1_diff);
                end else begin
                    s2_prod <= PW'(s1_diff) * PW'(s1_gain);
                end
            end

            // Stage 3 into shadow
            if (s2_v) begin
                shadow[s2_ch] <= res_w;
            end

            unique case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        for (int c = 0; c < N_CH; c++) begin
                            lat[c] <= adc_in[c*W +: W];
                        end
                        lat_byp <= bypass;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(N_CH - 1)) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Last channel reaches its shadow two edges after
                    // issue; publish the whole set on the edge after.
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == 2'd2) begin
                        for (int c = 0; c < N_CH; c++) begin
                            cal_out[c*W +: W] <= shadow[c];
                        end
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
